// File: rtl/ser_pkg.sv
// ----------------------------------------------------------------------------
// ser_pkg
// Definitions shared by the serial receiver and its matching transmitter:
//   rx_state_t  : receiver FSM states (IDLE, DATA, PARITY, STOP)
//   LINE_IDLE   : level of the serial line when no frame is in flight
//   START_BIT   : level that opens a frame
//   STOP_BIT    : level that closes a frame
// ----------------------------------------------------------------------------
package ser_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } rx_state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage : ser_pkg

// File: rtl/ser_rx4.sv
// ----------------------------------------------------------------------------
// ser_rx4
// Serial frame receiver: start bit, WIDTH data bits, optional even-parity
// bit, stop bit. One bit is taken per bit_en strobe; the word is handed to
// the consumer through a valid/ready output register.
//
// Parameters
//   WIDTH     : data bits per frame (2..8)
//   PARITY_EN : 1 = even-parity bit present, 0 = no parity bit
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   sin       : serial line (idles high)
//   bit_en    : bit-rate strobe, sin sampled only when high
//   dir       : 0 = LSB first, 1 = MSB first (captured with the start bit)
//   out_ready : consumer accepts dout when high with out_valid
//   dout      : received word, stable while out_valid
//   out_valid : dout holds an unconsumed word
//   par_err   : parity status of the word in dout
//   frm_err   : one-cycle pulse on a bad stop bit
//   overrun   : one-cycle pulse when a completed word is dropped
//   busy      : FSM is not in IDLE
// ----------------------------------------------------------------------------
module ser_rx4
   import ser_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int PARITY_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             bit_en,
   input  logic             dir,
   input  logic             out_ready,
   output logic [WIDTH-1:0] dout,
   output logic             out_valid,
   output logic             par_err,
   output logic             frm_err,
   output logic             overrun,
   output logic             busy
);

   localparam int              CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   rx_state_t        state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] shift_next;
   logic             dir_reg;
   logic             par_bad_reg;
   logic [WIDTH-1:0] dout_reg;
   logic             out_valid_reg;
   logic             par_err_reg;
   logic             frm_err_reg;
   logic             overrun_reg;

   // MSB-first enters at bit 0 and moves left; LSB-first enters at the top
   // and moves right, so after WIDTH samples the first bit lands in bit 0.
   always_comb begin
      shift_next = shift_reg;
      if (dir_reg)
         shift_next = {shift_reg[WIDTH-2:0], sin};
      else
         shift_next = {sin, shift_reg[WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         shift_reg     <= '0;
         dir_reg       <= 1'b0;
         par_bad_reg   <= 1'b0;
         dout_reg      <= '0;
         out_valid_reg <= 1'b0;
         par_err_reg   <= 1'b0;
         frm_err_reg   <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         frm_err_reg <= 1'b0;
         overrun_reg <= 1'b0;

         // Consumption; a completion below in the same cycle overrides it.
         if (out_valid_reg && out_ready)
            out_valid_reg <= 1'b0;

         if (bit_en) begin
            case (state_reg)
               IDLE: begin
                  if (sin == START_BIT) begin
                     state_reg   <= DATA;
                     cnt_reg     <= '0;
                     dir_reg     <= dir;
                     par_bad_reg <= 1'b0;
                  end
               end
               DATA: begin
                  shift_reg <= shift_next;
                  if (cnt_reg == CNT_LAST) begin
                     cnt_reg   <= '0;
                     state_reg <= (PARITY_EN != 0) ? PARITY : STOP;
                  end else begin
                     cnt_reg <= cnt_reg + 1'b1;
                  end
               end
               PARITY: begin
                  par_bad_reg <= ((^shift_reg) != sin);
                  state_reg   <= STOP;
               end
               STOP: begin
                  // A low stop bit is never reused as a start bit.
                  state_reg <= IDLE;
                  if (sin == STOP_BIT) begin
                     if (!out_valid_reg || out_ready) begin
                        dout_reg      <= shift_reg;
                        par_err_reg   <= par_bad_reg;
                        out_valid_reg <= 1'b1;
                     end else begin
                        overrun_reg <= 1'b1;
                     end
                  end else begin
                     frm_err_reg <= 1'b1;
                  end
               end
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

   assign dout      = dout_reg;
   assign out_valid = out_valid_reg;
   assign par_err   = par_err_reg;
   assign frm_err   = frm_err_reg;
   assign overrun   = overrun_reg;
   assign busy      = (state_reg != IDLE);

endmodule : ser_rx4

// File: doc/ser_rx4.md
SER_RX4 -- requirements
Module: ser_rx4

Interface
REQ-001 Parameter: WIDTH, default 4, data bits per frame (legal range 2..8).
REQ-002 Parameter: PARITY_EN, default 1; 1 = even-parity bit present in frame, 0 = no parity bit.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: sin  input  1  serial line; idles high.
REQ-006 Port: bit_en  input  1  bit-rate strobe; sin is sampled only on cycles with bit_en=1.
REQ-007 Port: dir  input  1  0 = LSB-first, 1 = MSB-first; sampled with the start bit and held for the frame.
REQ-008 Port: out_ready  input  1  consumer accepts dout when high together with out_valid.
REQ-009 Port: dout  output  WIDTH  received word, stable while out_valid=1.
REQ-010 Port: out_valid  output  1  dout holds an unconsumed word.
REQ-011 Port: par_err  output  1  parity status of the word in dout, valid while out_valid=1.
REQ-012 Port: frm_err  output  1  one-cycle pulse on a bad stop bit.
REQ-013 Port: overrun  output  1  one-cycle pulse when a completed word is dropped.
REQ-014 Port: busy  output  1  high in every state other than IDLE.

Function
REQ-015 The frame SHALL be: start (0), WIDTH data bits, parity (if PARITY_EN), stop (1); one bit per bit_en sample.
REQ-016 The FSM SHALL have states IDLE, DATA, PARITY, STOP; transitions occur only on bit_en cycles.
REQ-017 IDLE->DATA on sampled sin=0; sampled sin=1 stays in IDLE.
REQ-018 DATA SHALL shift sin into the assembly register (into bit 0 moving left when dir=1, into bit WIDTH-1 moving right when dir=0); a bit counter of width clog2(WIDTH) SHALL count WIDTH samples, then go to PARITY (PARITY_EN=1) or STOP.
REQ-019 PARITY SHALL record the error as (XOR of data bits) != sampled bit, then go to STOP.
REQ-020 STOP with sin=1 SHALL complete the frame; STOP with sin=0 SHALL discard the word, pulse frm_err the next cycle and return to IDLE, not treating that 0 as a new start bit.
REQ-021 On completion, dout, par_err and out_valid=1 SHALL be registered one cycle after the stop-bit sample.
REQ-022 A word with a parity error SHALL still be delivered, with par_err=1.
REQ-023 out_valid SHALL clear the cycle after out_valid && out_ready; dout is unchanged until the next load.
REQ-024 If a completion occurs while out_valid=1 and out_ready=0, the new word SHALL be dropped, dout is kept, and overrun pulses one cycle.
REQ-025 If completion and consumption (out_valid && out_ready) occur in the same cycle, the new word SHALL load and out_valid stays 1, with no overrun.
REQ-026 A dir change mid-frame SHALL have no effect until the next start bit.
REQ-027 bit_en gaps of any length SHALL only stall the FSM; they SHALL NOT reset it.

Reset
REQ-028 rst=0 SHALL immediately force IDLE, bit counter=0, assembly register=0, dout=0, out_valid=0, par_err=0, frm_err=0, overrun=0, busy=0.
REQ-029 Reset mid-frame SHALL abandon the frame with no output; the first start bit after release SHALL begin a fresh frame.

Structure
REQ-030 Shared package ser_pkg SHALL hold the state enum (IDLE, DATA, PARITY, STOP) and the line constants LINE_IDLE=1, START_BIT=0, STOP_BIT=1, shared with the future matching transmitter.
REQ-031 Implementation SHALL be a single module with no sub-modules; FSM, counter, shifter and output register live in ser_rx4.

Verification (WIDTH=4, PARITY_EN=1, bit_en every cycle unless stated)
REQ-032 dir=0, sin sequence 0,1,1,0,1,1,1 with out_ready=1 -> dout=4'b1011, par_err=0, out_valid for 1 cycle.
REQ-033 dir=1, sin sequence 0,1,0,1,1,1,1 -> dout=4'b1011, par_err=0.
REQ-034 dir=0, sin sequence 0,1,1,0,1,0,1 -> dout=4'b1011, par_err=1.
REQ-035 Valid frame, then stop bit=0 on a second frame -> frm_err pulses once, out_valid stays 0 for that frame, FSM returns to IDLE.
REQ-036 out_ready=0, two back-to-back frames 4'b1011 then 4'b0100 -> dout remains 4'b1011, overrun pulses once; a repeat with out_ready=1 in the completion cycle -> dout=4'b0100 and no overrun.
REQ-037 rst=0 asserted after the 2nd data bit with bit_en every 3rd cycle -> all outputs are 0 immediately; a following full frame is received correctly.
